// File: rtl/sc_regfile_scratchpad.sv
// sc_regfile_scratchpad: 16x32 scratchpad register file with r0 tied to zero, a PC (r13) auto-increment path and an IR (r15) load path.
module sc_regfile_scratchpad #(
    parameter int                       DATAWIDTH_BUS     = 32,
    parameter int                       DATAWIDTH_ADDRESS = 6,
    parameter logic [DATAWIDTH_BUS-1:0] RESET_PC          = '0
) (
    input  logic                         SC_REGFILE_CLOCK_50,
    input  logic                         SC_REGFILE_RESET_InHigh,
    input  logic                         SC_REGFILE_Write_In,
    input  logic [DATAWIDTH_ADDRESS-1:0] SC_REGFILE_WriteAddress_InBus,
    input  logic [DATAWIDTH_BUS-1:0]     SC_REGFILE_CBus_InBus,
    input  logic                         SC_REGFILE_PCIncrement_In,
    input  logic                         SC_REGFILE_IRLoad_In,
    input  logic [DATAWIDTH_BUS-1:0]     SC_REGFILE_IRData_InBus,
    output logic [DATAWIDTH_BUS-1:0]     SC_REGFILE_data0_OutBus,
    output logic [DATAWIDTH_BUS-1:0]     SC_REGFILE_data1_OutBus,
    output logic [DATAWIDTH_BUS-1:0]     SC_REGFILE_data2_OutBus,
    output logic [DATAWIDTH_BUS-1:0]     SC_REGFILE_data3_OutBus,
    output logic [DATAWIDTH_BUS-1:0]     SC_REGFILE_data4_OutBus,
    output logic [DATAWIDTH_BUS-1:0]     SC_REGFILE_data5_OutBus,
    output logic [DATAWIDTH_BUS-1:0]     SC_REGFILE_data6_OutBus,
    output logic [DATAWIDTH_BUS-1:0]     SC_REGFILE_data7_OutBus,
    output logic [DATAWIDTH_BUS-1:0]     SC_REGFILE_data8_OutBus,
    output logic [DATAWIDTH_BUS-1:0]     SC_REGFILE_data9_OutBus,
    output logic [DATAWIDTH_BUS-1:0]     SC_REGFILE_data10_OutBus,
    output logic [DATAWIDTH_BUS-1:0]     SC_REGFILE_data11_OutBus,
    output logic [DATAWIDTH_BUS-1:0]     SC_REGFILE_data12_OutBus,
    output logic [DATAWIDTH_BUS-1:0]     SC_REGFILE_data13_OutBus,
    output logic [DATAWIDTH_BUS-1:0]     SC_REGFILE_data14_OutBus,
    output logic [DATAWIDTH_BUS-1:0]     SC_REGFILE_data15_OutBus,
    output logic                         SC_REGFILE_IllegalWrite_Out
);
    logic [DATAWIDTH_BUS-1:0] regs [1:15];
    logic [3:0] wrIdx;
    logic inRange, wrLegal, wrPc, wrIr;
    assign wrIdx   = SC_REGFILE_WriteAddress_InBus[3:0];
    assign inRange = SC_REGFILE_WriteAddress_InBus[DATAWIDTH_ADDRESS-1:4] == '0;
    assign wrLegal = SC_REGFILE_Write_In && inRange;
    assign wrPc    = wrLegal && wrIdx == 4'd13;
    assign wrIr    = wrLegal && wrIdx == 4'd15;
    always_ff @(posedge SC_REGFILE_CLOCK_50) begin
        if (SC_REGFILE_RESET_InHigh) begin
            for (int i = 1; i < 16; i++) regs[i] <= '0;
            regs[13] <= RESET_PC;
            SC_REGFILE_IllegalWrite_Out <= 1'b0;
        end else begin
            for (int i = 1; i < 16; i++)
                if (wrLegal && wrIdx == 4'(i)) regs[i] <= SC_REGFILE_CBus_InBus;
            // PC and IR use opposite priorities: a fetch must beat a stale micro-write to IR
            regs[13] <= wrPc ? SC_REGFILE_CBus_InBus
                      : SC_REGFILE_PCIncrement_In ? regs[13] + DATAWIDTH_BUS'(4) : regs[13];
            regs[15] <= SC_REGFILE_IRLoad_In ? SC_REGFILE_IRData_InBus
                      : wrIr ? SC_REGFILE_CBus_InBus : regs[15];
            SC_REGFILE_IllegalWrite_Out <= SC_REGFILE_Write_In && !inRange;
        end
    end
    assign SC_REGFILE_data0_OutBus  = '0;
    assign SC_REGFILE_data1_OutBus  = regs[1];
    assign SC_REGFILE_data2_OutBus  = regs[2];
    assign SC_REGFILE_data3_OutBus  = regs[3];
    assign SC_REGFILE_data4_OutBus  = regs[4];
    assign SC_REGFILE_data5_OutBus  = regs[5];
    assign SC_REGFILE_data6_OutBus  = regs[6];
    assign SC_REGFILE_data7_OutBus  = regs[7];
    assign SC_REGFILE_data8_OutBus  = regs[8];
    assign SC_REGFILE_data9_OutBus  = regs[9];
    assign SC_REGFILE_data10_OutBus = regs[10];
    assign SC_REGFILE_data11_OutBus = regs[11];
    assign SC_REGFILE_data12_OutBus = regs[12];
    assign SC_REGFILE_data13_OutBus = regs[13];
    assign SC_REGFILE_data14_OutBus = regs[14];
    assign SC_REGFILE_data15_OutBus = regs[15];
endmodule

// File: tb/tb_sc_regfile_scratchpad.sv
// tb_sc_regfile_scratchpad: directed and randomized checks of the register file against an array-based reference model.
module tb_sc_regfile_scratchpad;
    localparam logic [31:0] RPC = 32'h0000_0100;
    logic clk = 1'b0;
    logic rst, wr, inc, ld;
    logic [5:0] addr;
    logic [31:0] cbus, irData;
    logic [31:0] dOut [16];
    logic ill;
    logic [31:0] m [16];
    logic mIll;
    int nVec = 0;
    int nBad = 0;

    always #5 clk = ~clk;

    sc_regfile_scratchpad #(.DATAWIDTH_BUS(32), .DATAWIDTH_ADDRESS(6), .RESET_PC(RPC)) dut (
        .SC_REGFILE_CLOCK_50(clk),
        .SC_REGFILE_RESET_InHigh(rst),
        .SC_REGFILE_Write_In(wr),
        .SC_REGFILE_WriteAddress_InBus(addr),
        .SC_REGFILE_CBus_InBus(cbus),
        .SC_REGFILE_PCIncrement_In(inc),
        .SC_REGFILE_IRLoad_In(ld),
        .SC_REGFILE_IRData_InBus(irData),
        .SC_REGFILE_data0_OutBus(dOut[0]),
        .SC_REGFILE_data1_OutBus(dOut[1]),
        .SC_REGFILE_data2_OutBus(dOut[2]),
        .SC_REGFILE_data3_OutBus(dOut[3]),
        .SC_REGFILE_data4_OutBus(dOut[4]),
        .SC_REGFILE_data5_OutBus(dOut[5]),
        .SC_REGFILE_data6_OutBus(dOut[6]),
        .SC_REGFILE_data7_OutBus(dOut[7]),
        .SC_REGFILE_data8_OutBus(dOut[8]),
        .SC_REGFILE_data9_OutBus(dOut[9]),
        .SC_REGFILE_data10_OutBus(dOut[10]),
        .SC_REGFILE_data11_OutBus(dOut[11]),
        .SC_REGFILE_data12_OutBus(dOut[12]),
        .SC_REGFILE_data13_OutBus(dOut[13]),
        .SC_REGFILE_data14_OutBus(dOut[14]),
        .SC_REGFILE_data15_OutBus(dOut[15]),
        .SC_REGFILE_IllegalWrite_Out(ill)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        assert (got === exp) else begin
            nBad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic checkAll();
        for (int k = 0; k < 16; k++) chk($sformatf("data%0d", k), dOut[k], m[k]);
        chk("illegalWrite", {31'b0, ill}, {31'b0, mIll});
    endtask

    // Reference: the register map and the two priority lists, computed from old state
    task automatic modelStep();
        logic [31:0] pc, ir;
        int a;
        pc = m[13];
        ir = m[15];
        a = int'(addr);
        if (rst) begin
            for (int k = 0; k < 16; k++) m[k] = 32'h0;
            m[13] = RPC;
            mIll = 1'b0;
        end else begin
            mIll = wr && a >= 16;
            if (wr && a >= 1 && a <= 15) m[a] = cbus;
            if (wr && a == 13) m[13] = cbus;
            else if (inc) m[13] = pc + 32'd4;
            else m[13] = pc;
            if (ld) m[15] = irData;
            else if (wr && a == 15) m[15] = cbus;
            else m[15] = ir;
        end
    endtask

    task automatic cyc(input logic r, input logic w, input logic [5:0] a, input logic [31:0] c,
                       input logic pi, input logic il, input logic [31:0] ird);
        rst = r; wr = w; addr = a; cbus = c; inc = pi; ld = il; irData = ird;
        modelStep();
        @(posedge clk);
        #1;
        checkAll();
    endtask

    initial begin
        for (int k = 0; k < 16; k++) m[k] = 32'h0;
        mIll = 1'b0;
        cyc(1, 1, 6'd5, 32'hDEAD_BEEF, 1, 1, 32'hCAFE_F00D);
        chk("rst_pc", dOut[13], RPC);
        chk("rst_r5", dOut[5], 32'h0);
        chk("rst_ir", dOut[15], 32'h0);
        cyc(0, 0, 6'd0, 32'h0, 0, 0, 32'h0);
        for (int k = 1; k < 16; k++) begin
            cyc(0, 1, 6'(k), 32'h1000_0000 + k, 0, 0, 32'h0);
            chk($sformatf("wr_r%0d", k), dOut[k], 32'h1000_0000 + k);
        end
        cyc(0, 0, 6'd0, 32'h0, 0, 0, 32'h0);
        cyc(0, 1, 6'd0, 32'hFFFF_FFFF, 0, 0, 32'h0);
        chk("r0_zero", dOut[0], 32'h0);
        chk("r0_noill", {31'b0, ill}, 32'h0);
        cyc(0, 0, 'x, 'x, 0, 0, 32'h0);
        chk("x_idle_r7", dOut[7], 32'h1000_0007);
        cyc(0, 1, 6'd13, 32'hFFFF_FFF8, 0, 0, 32'h0);
        cyc(0, 0, 6'd0, 32'h0, 1, 0, 32'h0);
        chk("pc_inc1", dOut[13], 32'hFFFF_FFFC);
        cyc(0, 0, 6'd0, 32'h0, 1, 0, 32'h0);
        chk("pc_wrap", dOut[13], 32'h0);
        cyc(0, 1, 6'd13, 32'h0000_0040, 1, 0, 32'h0);
        chk("pc_wr_beats_inc", dOut[13], 32'h40);
        cyc(0, 1, 6'd15, 32'h1234_5678, 0, 1, 32'h8200_6001);
        chk("ir_load_beats_wr", dOut[15], 32'h8200_6001);
        cyc(0, 1, 6'd15, 32'h1234_5678, 0, 0, 32'h0);
        chk("ir_wr", dOut[15], 32'h1234_5678);
        cyc(0, 1, 6'd16, 32'hAAAA_AAAA, 0, 0, 32'h0);
        chk("ill_16", {31'b0, ill}, 32'h1);
        cyc(0, 1, 6'd63, 32'h5555_5555, 0, 0, 32'h0);
        chk("ill_63", {31'b0, ill}, 32'h1);
        cyc(0, 0, 6'd0, 32'h0, 0, 0, 32'h0);
        chk("ill_clear", {31'b0, ill}, 32'h0);
        chk("ill_r0_alias", dOut[0], 32'h0);
        chk("ill_r15_keep", dOut[15], 32'h1234_5678);
        cyc(0, 1, 6'd3, 32'h0BAD_0003, 1, 1, 32'h0);
        cyc(1, 1, 6'd3, 32'h7777_7777, 1, 1, 32'h9999_9999);
        chk("midrst_r3", dOut[3], 32'h0);
        chk("midrst_pc", dOut[13], RPC);
        for (int n = 0; n < 10000; n++) begin
            logic [5:0] a;
            a = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) a = 6'd13;
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, a, $urandom(),
                $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0, $urandom());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end
endmodule
